uart_bus_master: RTL

- Command-processing bus initiator driven by a UART byte stream; the initiator counterpart to the team's UART-attached bus slaves.
- Consumes bytes from a uart_rx instance and decodes them as read/write commands.
- Issues single-beat bus transactions and returns ack or read data as bytes to a uart_tx instance.
- Used as a host/debug port for poking memory-mapped peripherals over serial.

---
 rtl/uart_bus_master_if.sv | 31 +++
 rtl/uart_bus_master.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master_if.sv
// Bus-side and UART-side handshake bundle for uart_bus_master.
// master: the command engine's view; slave: the surrounding UART/bus fabric.
interface uart_bus_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            i_rx_data;
    logic                  i_rx_data_valid;
    logic [7:0]            o_tx_data;
    logic                  o_tx_data_valid;
    logic                  i_tx_busy;
    logic                  o_bus_en;
    logic                  o_bus_rnw;
    logic [ADDR_WIDTH-1:0] o_bus_address;
    logic [DATA_WIDTH-1:0] o_bus_data_out;
    logic [DATA_WIDTH-1:0] i_bus_data_in;
    logic                  i_bus_data_valid;
    logic                  o_rx_dropped;

    modport master (
        input  i_rx_data, i_rx_data_valid, i_tx_busy, i_bus_data_in, i_bus_data_valid,
        output o_tx_data, o_tx_data_valid, o_bus_en, o_bus_rnw, o_bus_address,
               o_bus_data_out, o_rx_dropped
    );

    modport slave (
        output i_rx_data, i_rx_data_valid, i_tx_busy, i_bus_data_in, i_bus_data_valid,
        input  o_tx_data, o_tx_data_valid, o_bus_en, o_bus_rnw, o_bus_address,
               o_bus_data_out, o_rx_dropped
    );
endinterface

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: decodes 0x01 write / 0x02 read commands, replies 0xAA, 0xEE or read data.
// Optional read timeout enabled by UART_BUS_MASTER_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | waiting for opcode byte
//   ADDR     | collecting address bytes, MSB first
//   WDATA    | collecting write data bytes, MSB first
//   BUS_REQ  | one-cycle bus request
//   BUS_WAIT | waiting for read data
//   RESP     | sending response bytes to the transmitter
module uart_bus_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              n_rst,
    uart_bus_master_if.master bus
);
    localparam int AB   = ADDR_WIDTH / 8;
    localparam int DB   = DATA_WIDTH / 8;
    localparam int MAXB = (AB > DB) ? AB : DB;
    localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

    if ((ADDR_WIDTH % 8) != 0 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("uart_bus_master: widths must be multiples of 8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_REQ, BUS_WAIT, RESP} state_t;

    state_t                state, state_nx;
    logic                  is_read;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_sh, bus_addr, addr_shift;
    logic [DATA_WIDTH-1:0] wdata_sh, bus_dout, wdata_shift, resp_sh;
    logic                  resp_multi;
    logic                  tx_valid;
    logic                  rx_legal, rx_take, addr_last, data_last, resp_last, tx_acc, timeout;

    assign rx_legal    = (bus.i_rx_data == 8'h01) || (bus.i_rx_data == 8'h02);
    assign rx_take     = bus.i_rx_data_valid && (state inside {IDLE, ADDR, WDATA});
    assign addr_last   = (cnt == CW'(AB - 1));
    assign data_last   = (cnt == CW'(DB - 1));
    assign resp_last   = !resp_multi || data_last;
    assign tx_acc      = tx_valid && !bus.i_tx_busy;
    assign cnt_inc     = (cnt == CW'(MAXB - 1)) ? cnt : cnt + 1'b1;
    // Casting the concatenation keeps the low bits, i.e. shifts the new byte in at the LSB.
    assign addr_shift  = ADDR_WIDTH'({addr_sh, bus.i_rx_data});
    assign wdata_shift = DATA_WIDTH'({wdata_sh, bus.i_rx_data});

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt <= '0;
        end else if (state == BUS_REQ) begin
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 2);
        end else if (state == BUS_WAIT && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign timeout = (state == BUS_WAIT) && (tmo_cnt == '0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (bus.i_rx_data_valid) state_nx = rx_legal ? ADDR : RESP;
            ADDR:     if (bus.i_rx_data_valid && addr_last) state_nx = is_read ? BUS_REQ : WDATA;
            WDATA:    if (bus.i_rx_data_valid && data_last) state_nx = BUS_REQ;
            BUS_REQ:  if (!is_read || bus.i_bus_data_valid) state_nx = RESP;
                      else                                  state_nx = BUS_WAIT;
            BUS_WAIT: if (bus.i_bus_data_valid || timeout) state_nx = RESP;
            RESP:     if (tx_acc && resp_last) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            is_read    <= 1'b0;
            cnt        <= '0;
            addr_sh    <= '0;
            wdata_sh   <= '0;
            bus_addr   <= '0;
            bus_dout   <= '0;
            resp_sh    <= '0;
            resp_multi <= 1'b0;
            tx_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_rx_data_valid) begin
                    cnt <= '0;
                    if (rx_legal) begin
                        is_read <= (bus.i_rx_data == 8'h02);
                    end else begin
                        resp_sh    <= DATA_WIDTH'(8'hEE) << (DATA_WIDTH - 8);
                        resp_multi <= 1'b0;
                    end
                end
                ADDR: if (rx_take) begin
                    addr_sh <= addr_shift;
                    cnt     <= addr_last ? '0 : cnt_inc;
                    if (addr_last && is_read) bus_addr <= addr_shift;
                end
                WDATA: if (rx_take) begin
                    wdata_sh <= wdata_shift;
                    cnt      <= data_last ? '0 : cnt_inc;
                    if (data_last) begin
                        bus_addr <= addr_sh;
                        bus_dout <= wdata_shift;
                    end
                end
                BUS_REQ: begin
                    cnt <= '0;
                    if (!is_read) begin
                        resp_sh    <= DATA_WIDTH'(8'hAA) << (DATA_WIDTH - 8);
                        resp_multi <= 1'b0;
                    end else if (bus.i_bus_data_valid) begin
                        resp_sh    <= bus.i_bus_data_in;
                        resp_multi <= 1'b1;
                    end
                end
                BUS_WAIT: begin
                    if (bus.i_bus_data_valid) begin
                        resp_sh    <= bus.i_bus_data_in;
                        resp_multi <= 1'b1;
                    end else if (timeout) begin
                        resp_sh    <= DATA_WIDTH'(8'hEE) << (DATA_WIDTH - 8);
                        resp_multi <= 1'b0;
                    end
                end
                RESP: begin
                    // Valid is only raised from a low cycle, so every accepted byte is followed by a gap.
                    if (tx_acc) begin
                        tx_valid <= 1'b0;
                        resp_sh  <= resp_sh << 8;
                        cnt      <= cnt_inc;
                    end else if (!tx_valid) begin
                        tx_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_tx_data       = resp_sh[DATA_WIDTH-1 -: 8];
    assign bus.o_tx_data_valid = tx_valid;
    assign bus.o_bus_en        = (state == BUS_REQ);
    assign bus.o_bus_rnw       = is_read;
    assign bus.o_bus_address   = bus_addr;
    assign bus.o_bus_data_out  = bus_dout;
    assign bus.o_rx_dropped    = bus.i_rx_data_valid && (state inside {BUS_REQ, BUS_WAIT, RESP});
endmodule
